// File: rtl/arb_requester.sv
// arb_requester: four-channel request agent for the 4-input fixed-priority
// arbiter. It counts pending jobs per channel, raises REQ, decodes the
// registered GNT, runs a BURST_LEN-beat burst on the shared bus for the
// winning channel, then releases the arbiter through a one-cycle GAP.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   job[3:0]        one-cycle pulse per channel, adds one pending job
//   GNT[3:0]        registered grant from arbiter (1000=ch0, 0010=ch1,
//                   0001=ch2, 0100=ch3, anything else = no grant)
//   REQ[3:0]        registered request to arbiter
//   bus_valid/bus_ch/bus_beat/bus_last   burst beat outputs
//   done[3:0]       one-cycle pulse with the final beat of a channel's burst
//   ovf[3:0]        sticky, job dropped on a saturated pending counter
//   err_lost        sticky, grant lost or mismatched mid-burst
//   err_timeout     sticky, WAIT_GNT timeout
//
// Optional feature: define ARB_REQ_TIMEOUT_EN to abort WAIT_GNT after
// TIMEOUT cycles without a valid grant; otherwise err_timeout is held 0.
module arb_requester #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned PEND_W    = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] job,
  input  logic [3:0] GNT,
  output logic [3:0] REQ,
  output logic       bus_valid,
  output logic [1:0] bus_ch,
  output logic [7:0] bus_beat,
  output logic       bus_last,
  output logic [3:0] done,
  output logic [3:0] ovf,
  output logic       err_lost,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_BURST,
    S_GAP
  } state_t;

  localparam logic [7:0]        LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t            r_state;
  logic [3:0]        r_req;
  logic              r_valid;
  logic [1:0]        r_ch;
  logic [7:0]        r_beat;
  logic              r_last;
  logic [3:0]        r_done;
  logic [3:0]        r_ovf;
  logic              r_err_lost;
  logic [PEND_W-1:0] r_pend [4];

  logic       w_gnt_vld;
  logic [1:0] w_gnt_ch;
  logic [3:0] w_gnt_oh;
  logic [3:0] w_ch_oh;
  logic [3:0] w_pend_nz;
  logic [7:0] w_beat_nxt;
  logic       w_gnt_ok;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int unsigned       TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_to;
  assign err_timeout = r_err_to;
`else
  assign err_timeout = 1'b0;
`endif

  assign REQ       = r_req;
  assign bus_valid = r_valid;
  assign bus_ch    = r_ch;
  assign bus_beat  = r_beat;
  assign bus_last  = r_last;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign err_lost  = r_err_lost;

  // Grant decode: only the four exact one-hot codes are grants.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = 2'd0;
    case (GNT)
      4'b1000: begin w_gnt_vld = 1'b1; w_gnt_ch = 2'd0; end
      4'b0010: begin w_gnt_vld = 1'b1; w_gnt_ch = 2'd1; end
      4'b0001: begin w_gnt_vld = 1'b1; w_gnt_ch = 2'd2; end
      4'b0100: begin w_gnt_vld = 1'b1; w_gnt_ch = 2'd3; end
      default: begin w_gnt_vld = 1'b0; w_gnt_ch = 2'd0; end
    endcase
  end

  always_comb begin
    w_pend_nz = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_pend_nz[i] = (r_pend[i] != '0);
    end
  end

  assign w_gnt_oh   = 4'b0001 << w_gnt_ch;
  assign w_ch_oh    = 4'b0001 << r_ch;
  assign w_beat_nxt = r_beat + 8'd1;
  assign w_gnt_ok   = w_gnt_vld && (w_gnt_ch == r_ch);

  // Pending counters: done retires a job, job adds one; both together net zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_pend[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (job[i] && !r_done[i]) begin
          if (r_pend[i] == PEND_MAX) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_pend[i] <= r_pend[i] + PEND_ONE;
          end
        end else if (!job[i] && r_done[i]) begin
          r_pend[i] <= r_pend[i] - PEND_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_valid    <= 1'b0;
      r_ch       <= '0;
      r_beat     <= '0;
      r_last     <= 1'b0;
      r_done     <= '0;
      r_err_lost <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_err_to   <= 1'b0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          r_req <= '0;
          if (|w_pend_nz) begin
            r_req   <= w_pend_nz;
            r_state <= S_WAIT_GNT;
`ifdef ARB_REQ_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end

        S_WAIT_GNT: begin
          r_req <= w_pend_nz;
          if (w_gnt_vld && r_req[w_gnt_ch]) begin
            r_ch    <= w_gnt_ch;
            r_req   <= w_gnt_oh;
            r_beat  <= '0;
            r_valid <= 1'b1;
            r_last  <= (LAST_BEAT == 8'd0);
            if (LAST_BEAT == 8'd0) begin
              r_done <= w_gnt_oh;
            end
            r_state <= S_BURST;
          end
`ifdef ARB_REQ_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_err_to <= 1'b1;
            r_req    <= '0;
            r_state  <= S_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end

        S_BURST: begin
          // Beat 0 is exempt: GNT still reflects the pre-one-hot REQ there.
          if (r_beat != 8'd0 && !w_gnt_ok) begin
            r_err_lost <= 1'b1;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_beat     <= '0;
            r_ch       <= '0;
            r_req      <= '0;
            r_state    <= S_GAP;
          end else if (r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_beat  <= '0;
            r_ch    <= '0;
            r_req   <= '0;
            r_state <= S_GAP;
          end else begin
            r_beat <= w_beat_nxt;
            if (w_beat_nxt == LAST_BEAT) begin
              r_last <= 1'b1;
              r_done <= w_ch_oh;
            end
          end
        end

        S_GAP: begin
          r_req   <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester with a live fixed-priority arbiter
// model (ch0>ch1>ch2>ch3) and a scoreboard of expected bus beats.
module tb_arb_requester;

  localparam int unsigned BL = 4;

  logic       clk;
  logic       reset;
  logic [3:0] job;
  logic [3:0] GNT;
  logic [3:0] REQ;
  logic       bus_valid;
  logic [1:0] bus_ch;
  logic [7:0] bus_beat;
  logic       bus_last;
  logic [3:0] done;
  logic [3:0] ovf;
  logic       err_lost;
  logic       err_timeout;

  arb_requester #(
    .BURST_LEN(BL),
    .PEND_W   (4),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job        (job),
    .GNT        (GNT),
    .REQ        (REQ),
    .bus_valid  (bus_valid),
    .bus_ch     (bus_ch),
    .bus_beat   (bus_beat),
    .bus_last   (bus_last),
    .done       (done),
    .ovf        (ovf),
    .err_lost   (err_lost),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbiter model with override for forcing a particular GNT.
  logic       frc_en;
  logic [3:0] frc_val;
  function automatic logic [3:0] arb(input logic [3:0] r);
    if (r[0])      return 4'b1000;
    else if (r[1]) return 4'b0010;
    else if (r[2]) return 4'b0001;
    else if (r[3]) return 4'b0100;
    else           return 4'b0000;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset)      GNT <= 4'b0;
    else if (frc_en) GNT <= frc_val;
    else             GNT <= arb(REQ);
  end

  // Scoreboard of expected beats.
  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] beat;
    logic       last;
    logic [3:0] done;
  } beat_t;
  beat_t sb_q[$];
  logic  mon_en;

  task automatic push_burst(input logic [1:0] ch);
    beat_t e;
    for (int unsigned b = 0; b < BL; b++) begin
      e.ch   = ch;
      e.beat = 8'(b);
      e.last = (b == BL - 1);
      e.done = (b == BL - 1) ? (4'b0001 << ch) : 4'b0;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (mon_en && reset) begin
      if (bus_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", {bus_ch, bus_beat, bus_last, done}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("beat", {bus_ch, bus_beat, bus_last, done}, {e.ch, e.beat, e.last, e.done});
        end
      end else begin
        chk("done_idle", done, 4'b0);
      end
    end
  end

  function automatic logic [15:0] pend_all();
    return {dut.r_pend[3], dut.r_pend[2], dut.r_pend[1], dut.r_pend[0]};
  endfunction

  task automatic drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus_valid && REQ == 4'b0) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk(name, ok, 1);
  endtask

  task automatic wait_beat(input logic [7:0] b);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_valid && bus_beat == b) found = 1'b1;
    end
    chk("wait_beat", found, 1);
  endtask

  typedef struct packed {
    logic [3:0] job;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] n;
    logic [7:0] ord;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit quiet;
    reset   = 1'b0;
    job     = 4'b0;
    frc_en  = 1'b0;
    frc_val = 4'b0;
    mon_en  = 1'b0;

    vecs[0] = '{job: 4'b0100, req: 4'b0100, gnt: 4'b0001, n: 3'd1, ord: 8'b00_00_00_10};
    vecs[1] = '{job: 4'b0001, req: 4'b0001, gnt: 4'b1000, n: 3'd1, ord: 8'b00_00_00_00};
    vecs[2] = '{job: 4'b0010, req: 4'b0010, gnt: 4'b0010, n: 3'd1, ord: 8'b00_00_00_01};
    vecs[3] = '{job: 4'b1000, req: 4'b1000, gnt: 4'b0100, n: 3'd1, ord: 8'b00_00_00_11};
    vecs[4] = '{job: 4'b1001, req: 4'b1001, gnt: 4'b1000, n: 3'd2, ord: 8'b00_00_11_00};
    vecs[5] = '{job: 4'b0110, req: 4'b0110, gnt: 4'b0010, n: 3'd2, ord: 8'b00_00_10_01};
    vecs[6] = '{job: 4'b1111, req: 4'b1111, gnt: 4'b1000, n: 3'd4, ord: 8'b11_10_01_00};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {REQ, bus_valid, bus_ch, bus_beat, bus_last, done, ovf, err_lost, err_timeout}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {REQ, bus_valid}, 32'h0);
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      job = vecs[v].job;
      for (int k = 0; k < int'(vecs[v].n); k++) push_burst(vecs[v].ord[2*k +: 2]);
      @(negedge clk);
      job = 4'b0;
      @(negedge clk);
      chk("req_plus1", REQ, vecs[v].req);
      @(negedge clk);
      chk("gnt_plus2", GNT, vecs[v].gnt);
      chk("valid_plus2", bus_valid, 0);
      @(negedge clk);
      chk("valid_plus3", bus_valid, 1);
      drain("drain_vec", 200);
      chk("pend_clear_vec", pend_all(), 16'h0);
    end

    // Grant lost on beat 2 of a ch1 burst.
    mon_en = 1'b0;
    job = 4'b0010;
    @(negedge clk);
    job = 4'b0;
    wait_beat(8'd1);
    frc_en  = 1'b1;
    frc_val = 4'b1000;
    @(negedge clk);
    chk("lost_beat2", {bus_valid, bus_beat}, {1'b1, 8'd2});
    frc_en = 1'b0;
    @(negedge clk);
    chk("lost_err", err_lost, 1);
    chk("lost_valid_low", bus_valid, 0);
    chk("lost_pend_kept", pend_all(), 16'h0010);
    push_burst(2'd1);
    mon_en = 1'b1;
    drain("drain_retry", 100);
    chk("retry_pend_clear", pend_all(), 16'h0);
    chk("lost_sticky", err_lost, 1);

    // Saturation: 17 jobs on ch0 while the arbiter withholds grants.
    frc_en  = 1'b1;
    frc_val = 4'b0;
    repeat (17) begin
      job = 4'b0001;
      @(negedge clk);
    end
    job = 4'b0;
    @(negedge clk);
    chk("sat_pend", pend_all(), 16'h000F);
    chk("sat_ovf", ovf, 4'b0001);
`ifndef ARB_REQ_TIMEOUT_EN
    chk("sat_req", REQ, 4'b0001);
`endif
    for (int k = 0; k < 15; k++) push_burst(2'd0);
    frc_en = 1'b0;
    drain("drain_sat", 400);
    chk("sat_pend_clear", pend_all(), 16'h0);
    chk("ovf_sticky", ovf, 4'b0001);

`ifdef ARB_REQ_TIMEOUT_EN
    frc_en  = 1'b1;
    frc_val = 4'b0;
    job = 4'b0010;
    @(negedge clk);
    job = 4'b0;
    @(negedge clk);
    chk("to_req", REQ, 4'b0010);
    repeat (15) @(negedge clk);
    chk("to_not_yet", err_timeout, 0);
    @(negedge clk);
    chk("to_flag", err_timeout, 1);
    chk("to_req_drop", REQ, 4'b0);
    begin
      bit back;
      back = 1'b0;
      for (int i = 0; i < 4 && !back; i++) begin
        @(negedge clk);
        if (REQ == 4'b0010) back = 1'b1;
      end
      chk("to_req_back", back, 1);
    end
    chk("to_pend_kept", pend_all(), 16'h0010);
    push_burst(2'd1);
    frc_en = 1'b0;
    drain("drain_to", 100);
`else
    chk("timeout_tied", err_timeout, 0);
`endif

    // Reset in the middle of a burst.
    mon_en = 1'b0;
    job = 4'b0100;
    @(negedge clk);
    job = 4'b0;
    wait_beat(8'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_outputs", {REQ, bus_valid, bus_ch, bus_beat, bus_last, done, ovf, err_lost, err_timeout}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done != 4'b0 || bus_valid || REQ != 4'b0) quiet = 1'b0;
    end
    chk("post_reset_quiet", quiet, 1);
    chk("post_reset_pend", pend_all(), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/arb_requester.md
# arb_requester

Four-channel request agent that drives the REQ side of the team's 4-input fixed-priority arbiter and consumes its registered GNT vector. Each channel accumulates pending jobs. The agent raises requests, detects which channel won, and locks the request to that channel. It then runs a fixed-length burst on a shared downstream bus and releases the arbiter. It sits between the job sources and the arbiter/bus pair.

## Interface
- BURST_LEN, 4, beats per granted burst (1..256)
- PEND_W, 4, width of each channel's pending-job counter
- TIMEOUT, 16, cycles allowed in WAIT_GNT before abort (used only with the macro in Configuration)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- job  in  4  one-cycle pulse per channel; adds one pending job
- GNT  in  4  registered grant from arbiter
- REQ  out  4  request to arbiter, registered
- bus_valid  out  1  burst beat valid
- bus_ch  out  2  channel owning current beat
- bus_beat  out  8  beat index, 0..BURST_LEN-1
- bus_last  out  1  high on final beat
- done  out  4  one-cycle pulse on channel whose burst completed
- ovf  out  4  sticky; job arrived while channel's counter was saturated
- err_lost  out  1  sticky; grant lost or mismatched mid-burst
- err_timeout  out  1  sticky; WAIT_GNT timeout (macro only, else tied 0)

## Operation
- Grant decode is fixed:
  - GNT=4'b1000 → ch0
  - GNT=4'b0010 → ch1
  - GNT=4'b0001 → ch2
  - GNT=4'b0100 → ch3
  - Any other value, including 0 and multi-hot, is "no grant".
- Priority is ch0>ch1>ch2>ch3 (owned by the arbiter, not this block).
- pend[i]:
  - increments on job[i]
  - decrements on done[i]
  - job[i] and done[i] in the same cycle gives net zero
  - saturates at 2^PEND_W-1; an extra job sets ovf[i] and is dropped
- FSM states: IDLE, WAIT_GNT, BURST, GAP.
  - IDLE: REQ=0. If any pend[i]≠0, go to WAIT_GNT with REQ[i]=(pend[i]≠0) for all i.
  - WAIT_GNT: REQ tracks the nonzero-pending mask every cycle. When the decoded grant names channel c with REQ[c]=1, latch c, set REQ to one-hot c, go to BURST, beat=0.
  - BURST: bus_valid=1, bus_ch=c, bus_beat counts 0..BURST_LEN-1, bus_last at BURST_LEN-1.
    - Each cycle, the decoded grant must equal c. If not: set err_lost, deassert bus_valid next cycle, go to GAP. pend[c] is unchanged so the job retries.
    - On the last beat: pulse done[c] and go to GAP.
  - GAP: REQ=0 and bus_valid=0 for exactly one cycle, then IDLE. This lets lower-priority channels win next.
- Reset at any state forces IDLE and all outputs and counters to 0, including sticky flags. An in-flight burst is discarded without a done pulse.

## Timing
- The REQ register update and the state change happen on the same edge.
- No-contention latency, counted from the edge that registers the job (pend=1):
  - +1 edge: REQ asserted
  - +2 edge: GNT valid
  - +3 edge: first beat
- Burst occupies exactly BURST_LEN consecutive cycles; done[c] coincides with bus_last.
- The grant check is skipped on beat 0. The arbiter's one-cycle lag on one-hot REQ keeps the grant stable because the winner is unchanged.
- Back-to-back burst on the same channel: minimum cycle count is BURST_LEN + 4 (GAP, IDLE, WAIT_GNT ×2).

## Configuration
- ARB_REQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_GNT.
  - If TIMEOUT cycles pass with no valid grant: set err_timeout, drop REQ, go to GAP.
  - Pending counts are unchanged.
- ARB_REQ_TIMEOUT_EN undefined:
  - No counter is built; WAIT_GNT waits indefinitely.
  - err_timeout is held 0.

## Test plan
- Single job on ch2, arbiter model live:
  - REQ=0100, then GNT=0001.
  - 4 beats with bus_ch=2, bus_beat 0..3, bus_last on beat 3.
  - done=0100, pend[2] returns to 0.
- Jobs on ch3 and ch0 in the same cycle:
  - REQ=1001, ch0 wins (GNT=1000).
  - After GAP, ch3 is served.
  - Exactly two done pulses, in order ch0 then ch3.
- During a ch1 burst, force GNT=1000 on beat 2 → err_lost=1, bus_valid low next cycle, pend[1] still 1, ch1 re-bursts afterwards.
- 17 job pulses on ch0 with PEND_W=4 and GNT held 0 → pend[0]=15, ovf[0]=1.
- With ARB_REQ_TIMEOUT_EN, TIMEOUT=16, GNT held 0, one job on ch1 → err_timeout=1 sixteen cycles after entering WAIT_GNT, REQ drops for one cycle, then reasserts 0010.
- Reset asserted on beat 1 of a burst → all outputs 0 immediately, no done pulse, IDLE after release.
